// File: rtl/window_chk_pkg.sv
// Shared types for the multi-channel window event checker.
// Channel state, failure cause encoding and cause width.
package window_chk_pkg;

    localparam int CAUSE_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } ch_state_e;

    typedef enum logic [CAUSE_W-1:0] {
        NONE    = 2'd0,
        EARLY   = 2'd1,
        TIMEOUT = 2'd2,
        EOT     = 2'd3
    } fail_cause_e;

endpackage

// File: rtl/window_event_chan.sv
// One checker channel: arm/decide FSM, window counter and latched bounds.
// Decision pulses are registered; next-state pulses are exported for the top.
module window_event_chan
    import window_chk_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               evt,
    input  logic               eot,
    input  logic               cfg_ok,
    input  logic [CNT_W-1:0]   cfg_min,
    input  logic [CNT_W-1:0]   cfg_max,
    output logic               busy,
    output logic               pass_p,
    output logic               fail_p,
    output logic [CAUSE_W-1:0] fail_cause,
    output logic               fail_d,
    output logic               ovl_d,
    output logic               cfg_rej
);

    ch_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic        pass_d;
    fail_cause_e cause_q, cause_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            pass_p  <= 1'b0;
            fail_p  <= 1'b0;
            cause_q <= NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            pass_p  <= pass_d;
            fail_p  <= fail_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        min_d   = min_q;
        max_d   = max_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        cause_d = NONE;
        ovl_d   = 1'b0;
        cfg_rej = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm && !eot) begin
                    if (cfg_ok) begin
                        state_d = ARMED;
                        cnt_d   = CNT_W'(1);
                        min_d   = cfg_min;
                        max_d   = cfg_max;
                    end else begin
                        cfg_rej = 1'b1;
                    end
                end
            end
            ARMED: begin
                ovl_d = arm;
                if (eot) begin
                    fail_d  = 1'b1;
                    cause_d = EOT;
                end else if (evt) begin
                    if (cnt_q < min_q) begin
                        fail_d  = 1'b1;
                        cause_d = EARLY;
                    end else begin
                        pass_d = 1'b1;
                    end
                end else if (max_q != '0 && cnt_q == max_q) begin
                    fail_d  = 1'b1;
                    cause_d = TIMEOUT;
                end else if (cnt_q != '1) begin
                    // unbounded windows park at all-ones instead of wrapping
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (fail_d || pass_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q == ARMED);
    assign fail_cause = cause_q;

endmodule

// File: rtl/window_event_checker.sv
// Multi-channel bounded-liveness monitor: per-channel [min,max] event windows,
// shared config check, sticky error flags and a saturating global fail count.
module window_event_checker
    import window_chk_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int ERRC_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CNT_W-1:0]          cfg_min,
    input  logic [CNT_W-1:0]          cfg_max,
    input  logic [NUM_CH-1:0]         arm,
    input  logic [NUM_CH-1:0]         evt,
    input  logic                      eot,
    input  logic                      clr_sticky,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         pass_p,
    output logic [NUM_CH-1:0]         fail_p,
    output logic [CAUSE_W*NUM_CH-1:0] fail_cause,
    output logic [NUM_CH-1:0]         fail_sticky,
    output logic [NUM_CH-1:0]         ovl_err,
    output logic                      cfg_err,
    output logic [ERRC_W-1:0]         fail_cnt
);

    localparam int PC_W = $clog2(NUM_CH + 1);

    logic              cfg_ok;
    logic [NUM_CH-1:0] fail_d;
    logic [NUM_CH-1:0] ovl_d;
    logic [NUM_CH-1:0] cfg_rej;
    logic [PC_W-1:0]   nfail;
    logic [ERRC_W:0]   cnt_sum;

    assign cfg_ok = (cfg_max == '0) || (cfg_min <= cfg_max);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        window_event_chan #(.CNT_W(CNT_W)) u_chan (
            .clk        (clk),
            .rst        (rst),
            .arm        (arm[i]),
            .evt        (evt[i]),
            .eot        (eot),
            .cfg_ok     (cfg_ok),
            .cfg_min    (cfg_min),
            .cfg_max    (cfg_max),
            .busy       (busy[i]),
            .pass_p     (pass_p[i]),
            .fail_p     (fail_p[i]),
            .fail_cause (fail_cause[CAUSE_W*i +: CAUSE_W]),
            .fail_d     (fail_d[i]),
            .ovl_d      (ovl_d[i]),
            .cfg_rej    (cfg_rej[i])
        );
    end

    always_comb begin
        nfail = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            nfail = nfail + PC_W'(fail_d[i]);
        end
    end

    assign cnt_sum = {1'b0, fail_cnt} + (ERRC_W + 1)'(nfail);

    // a fail landing on the clear edge keeps its sticky bit
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_sticky <= '0;
            ovl_err     <= '0;
            cfg_err     <= 1'b0;
            fail_cnt    <= '0;
        end else begin
            fail_sticky <= (fail_sticky & {NUM_CH{~clr_sticky}}) | fail_d;
            ovl_err     <= (ovl_err & {NUM_CH{~clr_sticky}}) | ovl_d;
            cfg_err     <= (cfg_err & ~clr_sticky) | (|cfg_rej);
            fail_cnt    <= cnt_sum[ERRC_W] ? '1 : cnt_sum[ERRC_W-1:0];
        end
    end

endmodule

// File: tb/tb_window_event_checker.sv
// Directed bench for window_event_checker.
// Each task drives one scenario and compares against hand-computed values.
module tb_window_event_checker;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int ERRC_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [CNT_W-1:0]  cfg_min;
    logic [CNT_W-1:0]  cfg_max;
    logic [NUM_CH-1:0] arm;
    logic [NUM_CH-1:0] evt;
    logic              eot;
    logic              clr_sticky;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] pass_p;
    logic [NUM_CH-1:0] fail_p;
    logic [2*NUM_CH-1:0] fail_cause;
    logic [NUM_CH-1:0] fail_sticky;
    logic [NUM_CH-1:0] ovl_err;
    logic              cfg_err;
    logic [ERRC_W-1:0] fail_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    window_event_checker #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .ERRC_W(ERRC_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_min(cfg_min), .cfg_max(cfg_max),
        .arm(arm), .evt(evt), .eot(eot), .clr_sticky(clr_sticky),
        .busy(busy), .pass_p(pass_p), .fail_p(fail_p),
        .fail_cause(fail_cause), .fail_sticky(fail_sticky),
        .ovl_err(ovl_err), .cfg_err(cfg_err), .fail_cnt(fail_cnt)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; cfg_min = '0; cfg_max = '0; arm = '0; evt = '0;
        eot = 1'b0; clr_sticky = 1'b0;
        tick(2);
        n_chk++;
        if ({busy, pass_p, fail_p, fail_cause, fail_sticky, ovl_err, cfg_err, fail_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h exp 0",
                {busy, pass_p, fail_p, fail_cause, fail_sticky, ovl_err, cfg_err, fail_cnt});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_pass_at_max;
        cfg_min = 8'd0; cfg_max = 8'd20;
        arm = 4'b0001; tick(); arm = '0;
        n_chk++;
        if (busy !== 4'b0001) begin
            n_fail++; $display("FAIL t1_busy got %b exp 0001", busy);
        end
        tick(19);
        n_chk++;
        if ({pass_p, fail_p} !== 8'h00) begin
            n_fail++; $display("FAIL t1_early_pulse got %h exp 00", {pass_p, fail_p});
        end
        evt = 4'b0001; tick(); evt = '0;
        n_chk++;
        if ({pass_p, fail_p, busy} !== 12'h100) begin
            n_fail++; $display("FAIL t1_pass got %h exp 100", {pass_p, fail_p, busy});
        end
        tick();
        n_chk++;
        if (pass_p !== 4'b0000) begin
            n_fail++; $display("FAIL t1_pass_width got %b exp 0000", pass_p);
        end
    endtask

    task automatic test_timeout;
        cfg_min = 8'd0; cfg_max = 8'd20;
        arm = 4'b0001; tick(); arm = '0;
        tick(19);
        n_chk++;
        if (fail_p !== 4'b0000 || busy !== 4'b0001) begin
            n_fail++; $display("FAIL t2_before_max got fail=%b busy=%b exp 0000/0001", fail_p, busy);
        end
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        n_chk++;
        if (fail_p !== 4'b0001 || fail_cause[1:0] !== 2'd2) begin
            n_fail++; $display("FAIL t2_timeout got fail=%b cause=%0d exp 0001/2", fail_p, fail_cause[1:0]);
        end
        n_chk++;
        if (fail_sticky !== 4'b0001 || fail_cnt !== 16'd1) begin
            n_fail++; $display("FAIL t2_sticky_cnt got sticky=%b cnt=%0d exp 0001/1", fail_sticky, fail_cnt);
        end
        tick();
    endtask

    task automatic test_min_window;
        cfg_min = 8'd5; cfg_max = 8'd10;
        arm = 4'b0001; tick(); arm = '0;
        tick(2);
        evt = 4'b0001; tick(); evt = '0;
        n_chk++;
        if (fail_p !== 4'b0001 || fail_cause[1:0] !== 2'd1 || fail_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL t3_early got fail=%b cause=%0d cnt=%0d exp 0001/1/2", fail_p, fail_cause[1:0], fail_cnt);
        end
        tick();
        arm = 4'b0001; tick(); arm = '0;
        tick(4);
        evt = 4'b0001; tick(); evt = '0;
        n_chk++;
        if (pass_p !== 4'b0001 || fail_p !== 4'b0000) begin
            n_fail++; $display("FAIL t3_pass_at_min got pass=%b fail=%b exp 0001/0000", pass_p, fail_p);
        end
        tick();
    endtask

    task automatic test_eot_unbounded;
        cfg_min = 8'd0; cfg_max = 8'd0;
        arm = 4'b0010; tick(); arm = '0;
        tick(300);
        n_chk++;
        if (busy !== 4'b0010 || fail_p !== 4'b0000) begin
            n_fail++; $display("FAIL t4_long_wait got busy=%b fail=%b exp 0010/0000", busy, fail_p);
        end
        eot = 1'b1; tick(); eot = 1'b0;
        n_chk++;
        if (fail_p !== 4'b0010 || fail_cause[3:2] !== 2'd3 || busy !== 4'b0000) begin
            n_fail++;
            $display("FAIL t4_eot got fail=%b cause=%0d busy=%b exp 0010/3/0000", fail_p, fail_cause[3:2], busy);
        end
        n_chk++;
        if (fail_cnt !== 16'd3 || fail_sticky[2] !== 1'b0) begin
            n_fail++; $display("FAIL t4_cnt got cnt=%0d sticky=%b exp 3/x0xx", fail_cnt, fail_sticky);
        end
        tick();
    endtask

    task automatic test_overlap;
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        n_chk++;
        if (fail_sticky !== 4'b0000) begin
            n_fail++; $display("FAIL t5_clear got %b exp 0000", fail_sticky);
        end
        cfg_min = 8'd0; cfg_max = 8'd10;
        arm = 4'b0001; tick(); arm = '0;
        tick(3);
        arm = 4'b0001; tick(); arm = '0;
        n_chk++;
        if (ovl_err !== 4'b0001 || busy !== 4'b0001) begin
            n_fail++; $display("FAIL t5_ovl got ovl=%b busy=%b exp 0001/0001", ovl_err, busy);
        end
        tick(5);
        n_chk++;
        if (fail_p !== 4'b0000 || busy !== 4'b0001) begin
            n_fail++; $display("FAIL t5_e9 got fail=%b busy=%b exp 0000/0001", fail_p, busy);
        end
        tick();
        n_chk++;
        if (fail_p !== 4'b0001 || fail_cause[1:0] !== 2'd2 || fail_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL t5_orig_window got fail=%b cause=%0d cnt=%0d exp 0001/2/4", fail_p, fail_cause[1:0], fail_cnt);
        end
        tick();
    endtask

    task automatic test_cfg_multi_reset;
        cfg_min = 8'd9; cfg_max = 8'd4;
        arm = 4'b1000; tick(); arm = '0;
        n_chk++;
        if (cfg_err !== 1'b1 || busy !== 4'b0000) begin
            n_fail++; $display("FAIL t6_cfg_err got err=%b busy=%b exp 1/0000", cfg_err, busy);
        end
        cfg_min = 8'd0; cfg_max = 8'd6;
        arm = 4'b1111; tick(); arm = '0;
        tick(5);
        n_chk++;
        if (fail_p !== 4'b0000 || busy !== 4'b1111) begin
            n_fail++; $display("FAIL t6_pre got fail=%b busy=%b exp 0000/1111", fail_p, busy);
        end
        tick();
        n_chk++;
        if (fail_p !== 4'b1111 || fail_cause !== 8'hAA || fail_cnt !== 16'd8) begin
            n_fail++;
            $display("FAIL t6_all_timeout got fail=%b cause=%h cnt=%0d exp 1111/aa/8", fail_p, fail_cause, fail_cnt);
        end
        tick();
        cfg_max = 8'd20;
        arm = 4'b0001; tick(); arm = '0;
        tick(6);
        rst = 1'b1; evt = 4'b0001; tick(); evt = '0;
        n_chk++;
        if ({busy, pass_p, fail_p, fail_cause, fail_sticky, ovl_err, cfg_err, fail_cnt} !== '0) begin
            n_fail++;
            $display("FAIL t6_rst_mid got %h exp 0",
                {busy, pass_p, fail_p, fail_cause, fail_sticky, ovl_err, cfg_err, fail_cnt});
        end
        rst = 1'b0;
        tick(2);
        n_chk++;
        if ({busy, pass_p, fail_p} !== 12'h000) begin
            n_fail++; $display("FAIL t6_post_rst got %h exp 000", {busy, pass_p, fail_p});
        end
    endtask

    initial begin
        test_reset();
        test_pass_at_max();
        test_timeout();
        test_min_window();
        test_eot_unbounded();
        test_overlap();
        test_cfg_multi_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
